burst_counter: RTL

- Parametrised successor to the fixed 2-bit load-triggered sequence counter.
- Started by a single-cycle load strobe; counts 0..term_cnt, then ends (one-shot) or wraps (continuous).
- Adds programmable terminal count, pause, abort, retrigger and status outputs.
- Sits beside the parallel-to-serial datapath and drives shift/slot selection and end-of-burst signalling.

---
 rtl/burst_counter.sv | 100 ++++++++++
 1 files changed

// File: rtl/burst_counter.sv
// burst_counter: load-triggered sequence counter with programmable terminal
// count, one-shot/continuous mode, pause, abort, retrigger and status flags.
module burst_counter #(
    parameter int WIDTH        = 4,
    parameter int DEFAULT_TERM = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_in_sync,
    input  logic [WIDTH-1:0] term_cnt,
    input  logic             mode_cont,
    input  logic             halt,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TERM_RST = WIDTH'(DEFAULT_TERM);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             at_term;

    assign at_term = (count_q == term_q);

    // State and datapath registers; reset drops any burst without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            term_q  <= TERM_RST;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Next state: abort beats load, load beats halt, halt beats advance
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        term_d  = term_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (load_in_sync) begin
            term_d  = term_cnt;
            mode_d  = mode_cont;
            count_d = '0;
            state_d = halt ? PAUSE : RUN;
        end else begin
            case (state_q)
                RUN, PAUSE: begin
                    if (halt) begin
                        state_d = PAUSE;
                    end else if (!at_term) begin
                        state_d = RUN;
                        count_d = count_q + WIDTH'(1);
                    end else begin
                        // End of sequence: wrap in continuous mode
                        count_d = '0;
                        done_d  = 1'b1;
                        state_d = mode_q ? RUN : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Outputs: all registered except last, which tracks halt directly
    always_comb begin
        count = count_q;
        busy  = (state_q != IDLE);
        done  = done_q;
        last  = busy & ~halt & at_term;
    end

endmodule
